// File: rtl/u_therm_decoder64.sv
// ----------------------------------------------------------------------------
// u_therm_decoder64
//
// Streaming 64-bit thermometer-to-binary decoder, the inverse of the 64-bit
// thermometer encoder. Thermometer words (ones packed from the LSB) enter
// over a valid/ready handshake. The ones level leaves two register stages
// later, together with a flag for words that were not legal thermometer
// codes. A saturating counter tracks how many accepted words were bubbles.
//
// Ports
//    i_clk        in   1         clock, rising edge
//    i_rstn       in   1         asynchronous active-low reset
//    i_in         in   64        thermometer word, bit0 = first segment
//    i_in_valid   in   1         i_in valid
//    o_in_ready   out  1         decoder accepts i_in this cycle
//    o_out        out  7         decoded level, 0..64
//    o_out_err    out  1         word behind o_out was a bubble
//    o_out_valid  out  1         o_out / o_out_err valid
//    i_out_ready  in   1         downstream accepts o_out this cycle
//    i_err_clr    in   1         synchronous clear of o_err_cnt
//    o_err_cnt    out  ERRCNT_W  saturating count of accepted bubble words
//
// Parameters
//    ERRCNT_W     width of the saturating bubble counter (default 16)
//
// Build option
//    THERM_BUBBLE_POPCNT_EN  defined: a bubble word decodes to its popcount.
//                            undefined: a bubble word decodes to the index
//                            of its highest set bit plus one.
//    Legal codes decode identically in both builds.
// ----------------------------------------------------------------------------
module u_therm_decoder64 #(
   parameter int ERRCNT_W = 16
) (
   input  logic                i_clk,
   input  logic                i_rstn,
   input  logic [63:0]         i_in,
   input  logic                i_in_valid,
   output logic                o_in_ready,
   output logic [6:0]          o_out,
   output logic                o_out_err,
   output logic                o_out_valid,
   input  logic                i_out_ready,
   input  logic                i_err_clr,
   output logic [ERRCNT_W-1:0] o_err_cnt
);

   localparam logic [ERRCNT_W-1:0] ERR_MAX = {ERRCNT_W{1'b1}};

   // Stage 1: raw word and its bubble flag
   logic        s1Valid_q, s1Valid_d;
   logic [63:0] s1Data_q,  s1Data_d;
   logic        s1Err_q,   s1Err_d;

   // Stage 2: decoded level and error flag, drives the outputs
   logic        s2Valid_q, s2Valid_d;
   logic [6:0]  s2Level_q, s2Level_d;
   logic        s2Err_q,   s2Err_d;

   logic [ERRCNT_W-1:0] errCnt_q, errCnt_d;

   logic        adv2;
   logic        inReady;
   logic        inXfer;
   logic        inBubble;
   logic [6:0]  s1Level;

   // A legal code 2^k-1 has no carry chain overlap: adding one clears every
   // set bit, so w & (w+1) is zero. The all-ones word wraps to zero and is
   // therefore also legal. Any remaining overlap means a gap below a one.
   always_comb begin
      inBubble = |(i_in & (i_in + 64'd1));
   end

   // Decode of the word held in stage 1. Both variants agree on legal codes;
   // they only differ in how ones above a gap are weighed.
`ifdef THERM_BUBBLE_POPCNT_EN
   always_comb begin
      s1Level = '0;
      for (int i = 0; i < 64; i++) begin
         s1Level = s1Level + 7'(s1Data_q[i]);
      end
   end
`else
   always_comb begin
      s1Level = '0;
      for (int i = 0; i < 64; i++) begin
         if (s1Data_q[i]) begin
            s1Level = 7'(i + 1);
         end
      end
   end
`endif

   // Handshake and next-state logic. Stage 2 advances when it is empty or
   // being drained; stage 1 can take a new word when it is empty or when it
   // is moving into stage 2 this cycle, which keeps a full pipe streaming at
   // one word per clock. Ready never looks at i_in_valid.
   always_comb begin
      adv2     = ~s2Valid_q | i_out_ready;
      inReady  = ~s1Valid_q | adv2;
      inXfer   = i_in_valid & inReady;

      s1Valid_d = s1Valid_q;
      s1Data_d  = s1Data_q;
      s1Err_d   = s1Err_q;
      s2Valid_d = s2Valid_q;
      s2Level_d = s2Level_q;
      s2Err_d   = s2Err_q;
      errCnt_d  = errCnt_q;

      if (inReady) begin
         s1Valid_d = i_in_valid;
         if (inXfer) begin
            s1Data_d = i_in;
            s1Err_d  = inBubble;
         end
      end

      // Data only moves on a real word, so an idle output keeps its last
      // value rather than picking up stale stage-1 contents.
      if (adv2) begin
         s2Valid_d = s1Valid_q;
         if (s1Valid_q) begin
            s2Level_d = s1Level;
            s2Err_d   = s1Err_q;
         end
      end

      // Clear wins over a same-cycle bubble; the counter sticks at its max.
      if (i_err_clr) begin
         errCnt_d = '0;
      end else if (inXfer && inBubble && (errCnt_q != ERR_MAX)) begin
         errCnt_d = errCnt_q + ERRCNT_W'(1);
      end
   end

   // State registers; reset empties the pipe so in-flight words vanish.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         s1Valid_q <= 1'b0;
         s1Data_q  <= '0;
         s1Err_q   <= 1'b0;
         s2Valid_q <= 1'b0;
         s2Level_q <= '0;
         s2Err_q   <= 1'b0;
         errCnt_q  <= '0;
      end else begin
         s1Valid_q <= s1Valid_d;
         s1Data_q  <= s1Data_d;
         s1Err_q   <= s1Err_d;
         s2Valid_q <= s2Valid_d;
         s2Level_q <= s2Level_d;
         s2Err_q   <= s2Err_d;
         errCnt_q  <= errCnt_d;
      end
   end

   // Output drive
   always_comb begin
      o_in_ready  = inReady;
      o_out       = s2Level_q;
      o_out_err   = s2Err_q;
      o_out_valid = s2Valid_q;
      o_err_cnt   = errCnt_q;
   end

endmodule

// File: tb/tb_u_therm_decoder64.sv
// ----------------------------------------------------------------------------
// tb_u_therm_decoder64
//
// Self-checking bench for u_therm_decoder64. A 16-bit-counter instance does
// the main work; a second instance with a 2-bit counter shares every input
// so its saturation can be observed on the same traffic. Expected levels
// come from a vector table and a small reference model and travel through a
// scoreboard queue from acceptance to delivery.
// ----------------------------------------------------------------------------
module tb_u_therm_decoder64;

   logic        i_clk = 1'b0;
   logic        i_rstn;
   logic [63:0] i_in;
   logic        i_in_valid;
   logic        i_out_ready;
   logic        i_err_clr;

   logic        o_in_ready;
   logic [6:0]  o_out;
   logic        o_out_err;
   logic        o_out_valid;
   logic [15:0] o_err_cnt;

   logic        inReady2;
   logic [6:0]  out2;
   logic        outErr2;
   logic        outValid2;
   logic [1:0]  errCnt2;

   // Clock generation
   always #5 i_clk = ~i_clk;

   u_therm_decoder64 #(.ERRCNT_W(16)) dut (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .i_in        (i_in),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .o_out       (o_out),
      .o_out_err   (o_out_err),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready),
      .i_err_clr   (i_err_clr),
      .o_err_cnt   (o_err_cnt)
   );

   u_therm_decoder64 #(.ERRCNT_W(2)) dutSat (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .i_in        (i_in),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (inReady2),
      .o_out       (out2),
      .o_out_err   (outErr2),
      .o_out_valid (outValid2),
      .i_out_ready (i_out_ready),
      .i_err_clr   (i_err_clr),
      .o_err_cnt   (errCnt2)
   );

`ifdef THERM_BUBBLE_POPCNT_EN
   localparam logic [6:0] LVL_F7   = 7'd7;
   localparam logic [6:0] LVL_MSB  = 7'd1;
   localparam logic [6:0] LVL_5    = 7'd2;
   localparam logic [6:0] LVL_FF56 = 7'd8;
`else
   localparam logic [6:0] LVL_F7   = 7'd8;
   localparam logic [6:0] LVL_MSB  = 7'd64;
   localparam logic [6:0] LVL_5    = 7'd3;
   localparam logic [6:0] LVL_FF56 = 7'd56;
`endif

   typedef struct {
      logic [63:0] word;
      logic [6:0]  level;
      logic        err;
   } vec_t;

   typedef struct {
      logic [6:0] level;
      logic       err;
   } exp_t;

   vec_t vecs[$];
   exp_t scoreQ[$];
   exp_t popped;

   int nCompared = 0;
   int nMismatch = 0;
   int expCnt16  = 0;
   int expCnt2   = 0;

   // Helper functions: thermometer word of k ones, legality by enumeration,
   // and the reference decode for arbitrary words.
   function automatic logic [63:0] ones(input int k);
      logic [64:0] t;
      t = (65'd1 << k) - 65'd1;
      return t[63:0];
   endfunction

   function automatic logic isLegal(input logic [63:0] w);
      for (int k = 0; k <= 64; k++) begin
         if (w == ones(k)) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [6:0] modelLevel(input logic [63:0] w);
      int lvl;
      lvl = 0;
`ifdef THERM_BUBBLE_POPCNT_EN
      for (int i = 0; i < 64; i++) lvl += int'(w[i]);
`else
      for (int i = 63; i >= 0; i--) begin
         if (w[i] && lvl == 0) lvl = i + 1;
      end
`endif
      return 7'(lvl);
   endfunction

   // One comparison: counts it and reports a line on mismatch.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatch++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Offer one word, wait (bounded) for acceptance, queue its expected
   // result, and leave inputs changing #1 after the accepting edge.
   task automatic applyStimulus(input logic [63:0] w, input logic [6:0] lvl,
                                input logic e);
      int waitCycles;
      waitCycles = 0;
      i_in       = w;
      i_in_valid = 1'b1;
      @(negedge i_clk);
      while (!o_in_ready && waitCycles < 100) begin
         waitCycles++;
         @(negedge i_clk);
      end
      if (o_in_ready) begin
         scoreQ.push_back('{level: lvl, err: e});
      end else begin
         nCompared++;
         nMismatch++;
         $display("[TB] FAIL acceptTimeout: got ready=0 for 100 clks, expected ready=1");
      end
      @(posedge i_clk);
      #1;
      i_in_valid = 1'b0;
   endtask

   // Scoreboard and counter model, sampled mid-cycle when everything that
   // decides the next edge is stable.
   always @(negedge i_clk) begin
      if (!i_rstn) begin
         scoreQ.delete();
         expCnt16 = 0;
         expCnt2  = 0;
      end else begin
         checkOutput("errCnt16", 64'(o_err_cnt), 64'(expCnt16));
         checkOutput("errCnt2",  64'(errCnt2),   64'(expCnt2));
         if (o_out_valid && i_out_ready) begin
            if (scoreQ.size() == 0) begin
               nCompared++;
               nMismatch++;
               $display("[TB] FAIL extraOutput: got level 0x%0h, expected no output", o_out);
            end else begin
               popped = scoreQ.pop_front();
               checkOutput("level", 64'(o_out), 64'(popped.level));
               checkOutput("err",   64'(o_out_err), 64'(popped.err));
            end
         end
         if (i_err_clr) begin
            expCnt16 = 0;
            expCnt2  = 0;
         end else if (i_in_valid && o_in_ready && !isLegal(i_in)) begin
            if (expCnt16 < 65535) expCnt16++;
            if (expCnt2 < 3) expCnt2++;
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [63:0] w;
      int          drainWait;

      i_rstn      = 1'b0;
      i_in        = '0;
      i_in_valid  = 1'b0;
      i_out_ready = 1'b1;
      i_err_clr   = 1'b0;

      // Vector table: legal sweep, then bubble and boundary words
      for (int k = 0; k <= 64; k++) vecs.push_back('{ones(k), 7'(k), 1'b0});
      vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 1'b0});
      vecs.push_back('{64'h8000_0000_0000_0000, LVL_MSB, 1'b1});
      vecs.push_back('{64'h0000_0000_0000_0005, LVL_5, 1'b1});
      vecs.push_back('{64'h00FF_0000_0000_0000, LVL_FF56, 1'b1});
      vecs.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 7'd63, 1'b0});
      vecs.push_back('{64'h0000_0000_0000_0000, 7'd0, 1'b0});

      // Reset state
      repeat (2) @(posedge i_clk);
      #1;
      checkOutput("rstValid",   64'(o_out_valid), 64'd0);
      checkOutput("rstOut",     64'(o_out), 64'd0);
      checkOutput("rstErr",     64'(o_out_err), 64'd0);
      checkOutput("rstCnt",     64'(o_err_cnt), 64'd0);
      checkOutput("rstInReady", 64'(o_in_ready), 64'd1);
      i_rstn = 1'b1;
      @(posedge i_clk);
      #1;

      // Legal sweep only, then a single F7 bubble
      for (int i = 0; i <= 64; i++) applyStimulus(vecs[i].word, vecs[i].level, vecs[i].err);
      checkOutput("sweepCnt", 64'(o_err_cnt), 64'd0);
      applyStimulus(64'h0000_0000_0000_00F7, LVL_F7, 1'b1);
      checkOutput("f7Cnt", 64'(o_err_cnt), 64'd1);

      // Remaining table entries back to back
      for (int i = 65; i < vecs.size(); i++) applyStimulus(vecs[i].word, vecs[i].level, vecs[i].err);

      // Stall for 5 clocks with both stages full
      fork
         begin
            for (int n = 0; n < 10; n++) applyStimulus(ones(n * 6 + 1), 7'(n * 6 + 1), 1'b0);
         end
         begin
            repeat (3) @(posedge i_clk);
            #1;
            i_out_ready = 1'b0;
            for (int c = 0; c < 5; c++) begin
               @(negedge i_clk);
               checkOutput("stallOut",     64'(o_out), 64'd7);
               checkOutput("stallValid",   64'(o_out_valid), 64'd1);
               checkOutput("stallInReady", 64'(o_in_ready), 64'd0);
            end
            @(posedge i_clk);
            #1;
            i_out_ready = 1'b1;
         end
      join

      // Random traffic with random backpressure
      fork
         begin
            for (int n = 0; n < 40; n++) begin
               if ($urandom_range(0, 2) == 0) w = {$urandom, $urandom};
               else w = ones(int'($urandom_range(0, 64)));
               applyStimulus(w, modelLevel(w), !isLegal(w));
            end
         end
         begin
            repeat (60) begin
               @(posedge i_clk);
               #1;
               i_out_ready = 1'($urandom_range(0, 1));
            end
            i_out_ready = 1'b1;
         end
      join
      i_out_ready = 1'b1;
      drainWait = 0;
      while (scoreQ.size() != 0 && drainWait < 20) begin
         @(posedge i_clk);
         drainWait++;
      end
      #1;
      checkOutput("drainQueue", 64'(scoreQ.size()), 64'd0);

      // Counter saturation and clear priority
      i_err_clr = 1'b1;
      @(posedge i_clk);
      #1;
      i_err_clr = 1'b0;
      for (int n = 0; n < 5; n++) applyStimulus(64'h0000_0000_0000_0005, LVL_5, 1'b1);
      checkOutput("satCnt2",  64'(errCnt2), 64'd3);
      checkOutput("satCnt16", 64'(o_err_cnt), 64'd5);
      i_err_clr = 1'b1;
      applyStimulus(64'h0000_0000_0000_0005, LVL_5, 1'b1);
      i_err_clr = 1'b0;
      checkOutput("clrCnt2",  64'(errCnt2), 64'd0);
      checkOutput("clrCnt16", 64'(o_err_cnt), 64'd0);
      repeat (3) @(posedge i_clk);
      #1;

      // Asynchronous reset with both stages full
      i_out_ready = 1'b0;
      applyStimulus(64'h0000_0000_0000_0005, LVL_5, 1'b1);
      applyStimulus(ones(9), 7'd9, 1'b0);
      checkOutput("preRstValid", 64'(o_out_valid), 64'd1);
      checkOutput("preRstCnt",   64'(o_err_cnt), 64'd1);
      i_rstn = 1'b0;
      #1;
      checkOutput("asyncRstValid", 64'(o_out_valid), 64'd0);
      checkOutput("asyncRstOut",   64'(o_out), 64'd0);
      checkOutput("asyncRstCnt",   64'(o_err_cnt), 64'd0);
      @(negedge i_clk);
      #2;
      i_rstn      = 1'b1;
      i_out_ready = 1'b1;
      @(posedge i_clk);
      #1;
      applyStimulus(ones(33), 7'd33, 1'b0);
      checkOutput("postRstEarly", 64'(o_out_valid), 64'd0);
      @(posedge i_clk);
      #1;
      checkOutput("postRstValid", 64'(o_out_valid), 64'd1);
      checkOutput("postRstOut",   64'(o_out), 64'd33);
      repeat (3) @(posedge i_clk);
      #1;
      checkOutput("finalQueue", 64'(scoreQ.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
